reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning the number of register-file entries addressed (index width 3).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the register data width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Clk  in  1  rising-edge clock for all state.
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 Start  in  1  dump request; sampled only in IDLE.
REQ-007 First  in  3  first register index; latched when Start is accepted.
REQ-008 Last  in  3  last register index; latched when Start is accepted.
REQ-009 Rd_sel  out  3  select to the register-file read port (SR2-style combinational read).
REQ-010 Rd_data  in  DATA_W  combinational read data for Rd_sel.
REQ-011 Out_valid  out  1  output word valid.
REQ-012 Out_ready  in  1  consumer ready.
REQ-013 Out_data  out  DATA_W  captured register value.
REQ-014 Out_idx  out  3  register index of Out_data.
REQ-015 Out_last  out  1  high with the final word of a dump.
REQ-016 Busy  out  1  high in every state except IDLE.
REQ-017 Done  out  1  one-cycle pulse after the final handshake.

Function
REQ-018 SHALL implement FSM states IDLE, SAMPLE, SEND, DONE.
REQ-019 IDLE: on Start=1, latch First/Last, load index = First, go to SAMPLE; otherwise stay.
REQ-020 SAMPLE: drive Rd_sel = index; at the clock edge capture Rd_data into Out_data, index into Out_idx, set Out_last = (index == Last); go to SEND.
REQ-021 SEND: Out_valid=1; Out_data/Out_idx/Out_last SHALL stay stable while Out_ready=0.
REQ-022 Handshake completes on an edge with Out_valid=1 and Out_ready=1; non-last -> index = (index+1) mod 8, go to SAMPLE; last -> DONE.
REQ-023 DONE: Done=1 for exactly one cycle, then IDLE.
REQ-024 Latency: Start accepted at edge k -> Out_valid first high in the cycle after edge k+1; each subsequent word needs one SAMPLE cycle after the prior handshake.
REQ-025 Word count SHALL be ((Last - First) mod 8) + 1, range 1..8; First==Last dumps one register.
REQ-026 Last < First SHALL wrap through index 7 to 0 (e.g. First=6, Last=1 -> 6,7,0,1).
REQ-027 Start while Busy=1 SHALL be ignored; changes on First/Last during a dump SHALL have no effect.
REQ-028 Out_valid SHALL never be high outside SEND; Rd_sel SHALL hold its last value outside SAMPLE.

Reset
REQ-029 Reset_n=0 SHALL asynchronously force state IDLE, index 0, Rd_sel 0, Out_valid 0, Out_data 0, Out_idx 0, Out_last 0, Busy 0, Done 0.
REQ-030 Reset asserted mid-dump SHALL abort the dump; no Done pulse; after release the block waits in IDLE for a new Start.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, REG_IDX_W=3 and DATA_W default constant.
REQ-032 One sub-module, idx_wrap_counter (3-bit loadable mod-8 incrementer with terminal compare against Last), SHALL be instantiated; all else in one module.

Verification
REQ-033 Full dump: R0..R7 = 16'h1000..16'h1007, First=0, Last=7, Out_ready=1 -> 8 words 1000..1007, Out_idx 0..7, Out_last only on idx 7, Done pulse once.
REQ-034 Wrap: First=6, Last=1 -> Out_idx sequence 6,7,0,1, Out_last on idx 1, 4 handshakes.
REQ-035 Backpressure: Out_ready=0 for 5 cycles on word idx 3 (value 16'hBEEF) -> Out_valid, Out_data=BEEF, Out_idx=3 held stable all 5 cycles; no word lost or duplicated.
REQ-036 Single: First=Last=5, R5=16'h00A5 -> exactly one word 00A5 with Out_last=1, Done pulse, Busy low one cycle later.
REQ-037 Start held high during a dump of 0..3 -> no restart; exactly 4 words; new dump begins only after IDLE is re-entered.
REQ-038 Reset_n pulsed low while in SEND on idx 2 -> all outputs 0 immediately, no Done pulse, next Start with First=0, Last=1 produces words 0,1 normally.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-dump reader.
//   state_e    : dump sequencer states
//   REG_IDX_W  : width of a register-file index
//   DATA_W_DEF : default register data width
package reg_dump_reader_pkg;

  localparam int unsigned REG_IDX_W  = 3;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_reader_idx.sv
// Loadable wrapping index counter with terminal compare.
//   i_clk/i_rst_n : clock, async active-low reset (index resets to 0)
//   i_load/i_load_val : load a new index (wins over i_inc)
//   i_inc         : advance index, wrapping NUM_REGS-1 -> 0
//   i_last        : terminal index to compare against
//   o_idx         : current index
//   o_at_last     : current index equals i_last
module idx_wrap_counter
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [REG_IDX_W-1:0] i_load_val,
  input  logic                 i_inc,
  input  logic [REG_IDX_W-1:0] i_last,
  output logic [REG_IDX_W-1:0] o_idx,
  output logic                 o_at_last
);

  localparam logic [REG_IDX_W-1:0] MAX_IDX = REG_IDX_W'(NUM_REGS - 1);

  logic [REG_IDX_W-1:0] r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if (i_load) begin
      r_idx <= i_load_val;
    end else if (i_inc) begin
      r_idx <= (r_idx == MAX_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  assign o_idx     = r_idx;
  assign o_at_last = (r_idx == i_last);

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a register file from First to Last (wrapping mod 8) and streams each
// entry out over a valid/ready interface, one SAMPLE cycle per word.
//   Clk, Reset_n        : clock, async active-low reset
//   Start, First, Last  : dump request and index range (taken in IDLE only)
//   Rd_sel, Rd_data     : combinational register-file read port
//   Out_valid/ready     : output handshake
//   Out_data/idx/last   : captured word, its index, final-word flag
//   Busy                : not idle
//   Done                : one-cycle pulse after the final handshake
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic [REG_IDX_W-1:0] First,
  input  logic [REG_IDX_W-1:0] Last,
  output logic [REG_IDX_W-1:0] Rd_sel,
  input  logic [DATA_W-1:0]    Rd_data,
  output logic                 Out_valid,
  input  logic                 Out_ready,
  output logic [DATA_W-1:0]    Out_data,
  output logic [REG_IDX_W-1:0] Out_idx,
  output logic                 Out_last,
  output logic                 Busy,
  output logic                 Done
);

  state_e               r_state;
  state_e               w_next;
  logic [REG_IDX_W-1:0] r_last;
  logic [DATA_W-1:0]    r_out_data;
  logic [REG_IDX_W-1:0] r_out_idx;
  logic                 r_out_last;
  logic                 w_load;
  logic                 w_inc;
  logic [REG_IDX_W-1:0] w_idx;
  logic                 w_at_last;

  idx_wrap_counter #(.NUM_REGS(NUM_REGS)) u_idx (
    .i_clk      (Clk),
    .i_rst_n    (Reset_n),
    .i_load     (w_load),
    .i_load_val (First),
    .i_inc      (w_inc),
    .i_last     (r_last),
    .o_idx      (w_idx),
    .o_at_last  (w_at_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_load = 1'b1;
          w_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: w_next = ST_SEND;
      ST_SEND: begin
        if (Out_ready) begin
          if (r_out_last) begin
            w_next = ST_DONE;
          end else begin
            w_inc  = 1'b1;
            w_next = ST_SAMPLE;
          end
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Last is held for the whole dump so input changes mid-dump are ignored.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last <= '0;
    end else if (r_state == ST_IDLE && Start) begin
      r_last <= Last;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_data <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
    end else if (r_state == ST_SAMPLE) begin
      r_out_data <= Rd_data;
      r_out_idx  <= w_idx;
      r_out_last <= w_at_last;
    end
  end

  // The index only moves when entering SAMPLE, so driving the read select
  // straight from it keeps Rd_sel stable in every other state.
  assign Rd_sel    = w_idx;
  assign Out_valid = (r_state == ST_SEND);
  assign Out_data  = r_out_data;
  assign Out_idx   = r_out_idx;
  assign Out_last  = r_out_last;
  assign Busy      = (r_state != ST_IDLE);
  assign Done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [2:0]  First;
  logic [2:0]  Last;
  logic [2:0]  Rd_sel;
  logic [15:0] Rd_data;
  logic        Out_valid;
  logic        Out_ready;
  logic [15:0] Out_data;
  logic [2:0]  Out_idx;
  logic        Out_last;
  logic        Busy;
  logic        Done;

  logic [15:0] mem [8];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 Clk = ~Clk;

  assign Rd_data = mem[Rd_sel];

  reg_dump_reader #(.NUM_REGS(8), .DATA_W(16)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .First     (First),
    .Last      (Last),
    .Rd_sel    (Rd_sel),
    .Rd_data   (Rd_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_data  (Out_data),
    .Out_idx   (Out_idx),
    .Out_last  (Out_last),
    .Busy      (Busy),
    .Done      (Done)
  );

  typedef struct {
    logic [2:0]      first;
    logic [2:0]      last;
    int unsigned     nwords;
    logic [7:0][2:0] seq;
    logic            stall_en;
    logic [2:0]      stall_idx;
    int unsigned     stall_n;
    logic            patch_en;
    logic [2:0]      patch_idx;
    logic [15:0]     patch_val;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic mem_init();
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  task automatic run_dump(input logic [2:0] f, input logic [2:0] l, input int unsigned n_exp,
                          input logic [7:0][2:0] seq, input logic stall_en,
                          input logic [2:0] stall_idx, input int unsigned stall_n,
                          input logic hold_start, input string tag);
    int unsigned got = 0;
    int unsigned cyc = 0;
    int unsigned stall_left = stall_n;
    bit finished = 0;
    @(posedge Clk); #1;
    Start = 1'b1; First = f; Last = l; Out_ready = 1'b1;
    @(posedge Clk); #1;
    if (!hold_start) Start = 1'b0;
    First = ~f; Last = ~l;
    chk($sformatf("%s_busy_acc", tag), 32'(Busy), 32'd1);
    chk($sformatf("%s_valid_in_sample", tag), 32'(Out_valid), 32'd0);
    chk($sformatf("%s_rdsel_first", tag), 32'(Rd_sel), 32'(f));
    while (!finished && cyc < 100) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 1) chk($sformatf("%s_latency", tag), 32'(Out_valid), 32'd1);
      if (Done) begin
        chk($sformatf("%s_word_count", tag), got, n_exp);
        @(posedge Clk); #1;
        chk($sformatf("%s_done_one_cycle", tag), 32'(Done), 32'd0);
        chk($sformatf("%s_busy_after_done", tag), 32'(Busy), 32'd0);
        finished = 1;
      end else if (Out_valid) begin
        if (got >= n_exp) begin
          chk($sformatf("%s_extra_word", tag), got, n_exp);
          Out_ready = 1'b1;
        end else begin
          chk($sformatf("%s_idx%0d", tag, got), 32'(Out_idx), 32'(seq[got]));
          chk($sformatf("%s_data%0d", tag, got), 32'(Out_data), 32'(mem[seq[got]]));
          chk($sformatf("%s_last%0d", tag, got), 32'(Out_last), 32'(got == n_exp - 1));
          chk($sformatf("%s_rdsel_hold%0d", tag, got), 32'(Rd_sel), 32'(seq[got]));
          if (stall_en && seq[got] == stall_idx && stall_left > 0) begin
            Out_ready = 1'b0;
            stall_left--;
          end else begin
            Out_ready = 1'b1;
            got++;
          end
        end
      end
    end
    if (!finished) chk($sformatf("%s_timeout", tag), 32'(cyc), 32'd0);
    if (stall_en) chk($sformatf("%s_stall_cycles_used", tag), stall_left, 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{3'd0, 3'd7, 8, {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, 1'b0, 3'd0, 0, 1'b0, 3'd0, 16'h0};
    vecs[1] = '{3'd6, 3'd1, 4, {3'd0,3'd0,3'd0,3'd0,3'd1,3'd0,3'd7,3'd6}, 1'b0, 3'd0, 0, 1'b0, 3'd0, 16'h0};
    vecs[2] = '{3'd5, 3'd5, 1, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd5}, 1'b0, 3'd0, 0, 1'b1, 3'd5, 16'h00A5};
    vecs[3] = '{3'd0, 3'd7, 8, {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, 1'b1, 3'd3, 5, 1'b1, 3'd3, 16'hBEEF};
    vecs[4] = '{3'd2, 3'd1, 8, {3'd1,3'd0,3'd7,3'd6,3'd5,3'd4,3'd3,3'd2}, 1'b0, 3'd0, 0, 1'b0, 3'd0, 16'h0};

    Reset_n = 1'b0; Start = 1'b0; First = '0; Last = '0; Out_ready = 1'b0;
    mem_init();
    #12;
    chk("rst_valid", 32'(Out_valid), 32'd0);
    chk("rst_busy",  32'(Busy),      32'd0);
    chk("rst_done",  32'(Done),      32'd0);
    chk("rst_data",  32'(Out_data),  32'd0);
    chk("rst_rdsel", 32'(Rd_sel),    32'd0);
    Reset_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      mem_init();
      if (vecs[v].patch_en) mem[vecs[v].patch_idx] = vecs[v].patch_val;
      run_dump(vecs[v].first, vecs[v].last, vecs[v].nwords, vecs[v].seq, vecs[v].stall_en,
               vecs[v].stall_idx, vecs[v].stall_n, 1'b0, $sformatf("v%0d", v));
    end

    // Start held high for a whole 0..3 dump: exactly 4 words, restart only from IDLE.
    mem_init();
    run_dump(3'd0, 3'd3, 4, {3'd0,3'd0,3'd0,3'd0,3'd3,3'd2,3'd1,3'd0}, 1'b0, 3'd0, 0, 1'b1, "hold");
    @(posedge Clk); #1;
    chk("hold_restart_from_idle", 32'(Busy), 32'd1);
    Start = 1'b0;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Reset pulsed while word idx 2 is waiting in SEND.
    begin
      bit hit = 0;
      @(posedge Clk); #1;
      Start = 1'b1; First = 3'd0; Last = 3'd7; Out_ready = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
        @(posedge Clk); #1;
        if (Out_valid && Out_idx == 3'd2) begin
          Out_ready = 1'b0;
          hit = 1;
        end
      end
      chk("rstmid_reached_idx2", 32'(hit), 32'd1);
      chk("rstmid_data_before", 32'(Out_data), 32'h1002);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("rstmid_valid", 32'(Out_valid), 32'd0);
      chk("rstmid_data",  32'(Out_data),  32'd0);
      chk("rstmid_idx",   32'(Out_idx),   32'd0);
      chk("rstmid_last",  32'(Out_last),  32'd0);
      chk("rstmid_busy",  32'(Busy),      32'd0);
      chk("rstmid_done",  32'(Done),      32'd0);
      chk("rstmid_rdsel", 32'(Rd_sel),    32'd0);
      Out_ready = 1'b1;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge Clk); #1;
        chk($sformatf("rstmid_idle_done%0d", i), 32'(Done), 32'd0);
        chk($sformatf("rstmid_idle_busy%0d", i), 32'(Busy), 32'd0);
      end
      run_dump(3'd0, 3'd1, 2, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd0}, 1'b0, 3'd0, 0, 1'b0, "after_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
